// File: rtl/aes128_encrypt_iter_if.sv
// rtl/aes128_encrypt_iter_if.sv - block handshake bundle for the iterative AES-128 encrypt core
interface aes128_encrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic [127:0] ciphertext;

  modport master (
    output in_valid, plaintext, key,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, plaintext, key,
    output in_ready, out_valid, ciphertext
  );
endinterface

// File: rtl/aes128_encrypt_iter.sv
// rtl/aes128_encrypt_iter.sv - iterative AES-128 encryption, one round per clock, on-the-fly key expansion
module aes128_encrypt_iter (
  input  logic                  clk,
  input  logic                  reset,
  aes128_encrypt_iter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [3:0]   round;
  logic         in_ready_r;
  logic         out_valid_r;

  logic [127:0] sub_st;
  logic [127:0] shift_st;
  logic [127:0] mix_st;
  logic [127:0] rk_next;
  logic [127:0] round_out;
  logic [31:0]  rot_w;
  logic [31:0]  key_tmp;

  // GF(2^8) multiply by x, reduced modulo 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box built as inverse (x^254, so 0 maps to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(gf_mul(gf_mul(x15, x15), gf_mul(x15, x15)),
                  gf_mul(gf_mul(x15, x15), gf_mul(x15, x15)));
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One cipher round plus the matching key-schedule step; byte i sits at [127-8i -: 8]
  always_comb begin
    sub_st   = '0;
    shift_st = '0;
    mix_st   = '0;
    for (int i = 0; i < 16; i++) begin
      sub_st[127-8*i -: 8] = sbox(state_reg[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_st[127-8*(4*c+r) -: 8] = sub_st[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_st[127-32*c -: 32] = mix_col(shift_st[127-32*c -: 32]);
    end

    rot_w   = {rk_reg[23:0], rk_reg[31:24]};
    key_tmp = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])}
              ^ {rcon(round), 24'h000000};
    rk_next[127:96] = rk_reg[127:96] ^ key_tmp;
    rk_next[95:64]  = rk_reg[95:64]  ^ rk_next[127:96];
    rk_next[63:32]  = rk_reg[63:32]  ^ rk_next[95:64];
    rk_next[31:0]   = rk_reg[31:0]   ^ rk_next[63:32];

    round_out = ((round == 4'd10) ? shift_st : mix_st) ^ rk_next;
  end

  // Control FSM with registered handshake outputs; accepts from IDLE or DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm         <= IDLE;
      state_reg   <= '0;
      rk_reg      <= '0;
      round       <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (fsm)
        IDLE, DONE: begin
          if (bus.in_valid && in_ready_r) begin
            state_reg   <= bus.plaintext ^ bus.key;
            rk_reg      <= bus.key;
            round       <= 4'd1;
            fsm         <= RUN;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
          end
        end
        RUN: begin
          state_reg <= round_out;
          rk_reg    <= rk_next;
          if (round == 4'd10) begin
            fsm         <= DONE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b1;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.ciphertext = state_reg;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// tb/tb_aes128_encrypt_iter.sv - scoreboard bench for the iterative AES-128 encrypt core
module tb_aes128_encrypt_iter;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic prev_ov = 1'b0;

  aes128_encrypt_iter_if bus();

  aes128_encrypt_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising out_valid pops one expected block and checks value and latency
  always @(negedge clk) begin
    if (bus.out_valid && !prev_ov) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h expected no output", bus.ciphertext);
      end else begin
        mon_e = sb_q.pop_front();
        check("ciphertext", bus.ciphertext, mon_e.ct);
        check("latency", 128'(cyc - mon_e.acc), 128'(11));
      end
    end
    prev_ov <= bus.out_valid;
  end

  // Called at a negedge with the core ready; returns at the negedge of RUN cycle 1
  task automatic do_accept(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct);
    exp_t e;
    check("accept_in_ready", 128'(bus.in_ready), 128'(1));
    bus.in_valid  = 1'b1;
    bus.plaintext = pt;
    bus.key       = k;
    e.ct  = ct;
    e.acc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.plaintext = {4{$urandom()}};
    bus.key       = {4{$urandom()}};
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      failures++;
      $display("FAIL wait_valid_timeout: got out_valid=0 expected 1 within 20 cycles");
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 128'(bus.in_ready), 128'(1));
    check("reset_out_valid", 128'(bus.out_valid), 128'(0));
    check("reset_ciphertext", bus.ciphertext, 128'(0));
    reset = 1'b0;
    @(negedge clk);

    // App. B, then App. C.1 accepted on the first DONE cycle
    do_accept(PT_B, KEY_B, CT_B);
    wait_valid();
    do_accept(PT_C, KEY_C, CT_C);
    for (int k = 1; k <= 10; k++) begin
      check("b2b_out_valid_low", 128'(bus.out_valid), 128'(0));
      check("b2b_in_ready_low", 128'(bus.in_ready), 128'(0));
      @(negedge clk);
    end
    check("b2b_out_valid_high", 128'(bus.out_valid), 128'(1));

    // Hold in DONE with no new input
    for (int i = 0; i < 50; i++) begin
      check("hold_out_valid", 128'(bus.out_valid), 128'(1));
      check("hold_ciphertext", bus.ciphertext, CT_C);
      @(negedge clk);
    end

    // Busy rejection: different data offered in RUN cycles 3..7
    do_accept(PT_C, KEY_C, CT_C);
    for (int k = 1; k <= 10; k++) begin
      check("busy_in_ready", 128'(bus.in_ready), 128'(0));
      bus.in_valid  = (k >= 3 && k <= 7);
      bus.plaintext = PT_B;
      bus.key       = KEY_B;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("busy_done_valid", 128'(bus.out_valid), 128'(1));
    check("busy_done_ct", bus.ciphertext, CT_C);

    // Reset in RUN cycle 5 discards the block; a fresh block then completes
    do_accept(PT_B, KEY_B, CT_B);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_ciphertext", bus.ciphertext, 128'(0));
    reset = 1'b0;
    do_accept(PT_B, KEY_B, CT_B);
    wait_valid();
    @(negedge clk);
    check("scoreboard_empty", 128'(sb_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time 100000");
    $fatal(1);
  end

endmodule
